// File: rtl/bnn_weight_streamer.sv
// bnn_weight_streamer: transmit side of the BNN weight-load interface.
// Takes weight bytes over valid/ready and emits them as low/high nibble pairs
// on nibble + load_en. One session sends exactly NUM_NEURONS bytes.
// Optional feature: define BNN_WSTREAM_CHECKSUM_EN to add an 8-bit XOR checksum
// of the bytes accepted in the current session.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no session; waiting for start
// S_FETCH | waiting for an upstream byte (in_ready=1, load_en=0)
// S_LOW   | low nibble of byte_buf on the pins
// S_HIGH  | high nibble on the pins; next byte may be accepted here
// S_DONE  | one-cycle completion pulse
module bnn_weight_streamer #(
    parameter int NUM_NEURONS = 12,
    parameter int CNT_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             load_en,
    output logic [3:0]       nibble,
    output logic [CNT_W-1:0] neuron_idx,
    output logic             busy,
    output logic             done
`ifdef BNN_WSTREAM_CHECKSUM_EN
   ,output logic [7:0]       checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_NEURONS - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] byte_buf;
    logic       last_byte;
    logic       accept;
    logic       start_ok;
    logic       advance;

    assign last_byte = (neuron_idx == LAST_IDX);
    assign accept    = in_valid & in_ready;
    assign start_ok  = (state == S_IDLE) & start;
    // the high nibble has been taken by the core this cycle
    assign advance   = (state == S_HIGH) & ena;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // next-state logic; ena low holds the nibble phases so the core never loses a pair
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)    state_nxt = S_FETCH;
            S_FETCH: if (in_valid) state_nxt = S_LOW;
            S_LOW:   if (ena)      state_nxt = S_HIGH;
            S_HIGH: begin
                if (ena) begin
                    if (last_byte)     state_nxt = S_DONE;
                    else if (in_valid) state_nxt = S_LOW;
                    else               state_nxt = S_FETCH;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // outputs; only load_en and the HIGH-state in_ready see ena combinationally
    always_comb begin
        in_ready = 1'b0;
        load_en  = 1'b0;
        nibble   = 4'h0;
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        case (state)
            S_FETCH: in_ready = 1'b1;
            S_LOW: begin
                load_en = ena;
                nibble  = byte_buf[3:0];
            end
            S_HIGH: begin
                load_en  = ena;
                nibble   = byte_buf[7:4];
                in_ready = ena & ~last_byte;
            end
            default: ;
        endcase
    end

    // byte buffer loads only on a completed handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       byte_buf <= 8'h00;
        else if (accept) byte_buf <= in_data;
    end

    // count of bytes fully sent in this session
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         neuron_idx <= '0;
        else if (start_ok) neuron_idx <= '0;
        else if (advance)  neuron_idx <= neuron_idx + CNT_W'(1);
    end

`ifdef BNN_WSTREAM_CHECKSUM_EN
    // running XOR of accepted bytes, restarted by an honoured start
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         checksum <= 8'h00;
        else if (start_ok) checksum <= 8'h00;
        else if (accept)   checksum <= checksum ^ in_data;
    end
`endif

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Directed bench for bnn_weight_streamer with a behavioural core model on the
// nibble/load_en pins and a byte source driven from a small table.
module tb_bnn_weight_streamer;
    localparam int N = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       load_en;
    logic [3:0] nibble;
    logic [4:0] neuron_idx;
    logic       busy;
    logic       done;
`ifdef BNN_WSTREAM_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int n_chk = 0;
    int n_err = 0;

    bnn_weight_streamer #(.NUM_NEURONS(N), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .ena        (ena),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .load_en    (load_en),
        .nibble     (nibble),
        .neuron_idx (neuron_idx),
        .busy       (busy),
        .done       (done)
`ifdef BNN_WSTREAM_CHECKSUM_EN
       ,.checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    // byte source: src table, indexed by handshakes since src_base
    logic [7:0] src [N];
    int  acc_cnt = 0;
    int  src_base = 0;
    int  src_pos;
    bit  src_on = 1'b0;
    bit  stall = 1'b0;
    bit  fire = 1'b0;

    assign src_pos  = acc_cnt - src_base;
    assign in_data  = (src_pos < N) ? src[src_pos] : 8'h00;
    assign in_valid = src_on && !stall && (src_pos < N);

    always @(negedge clk) fire <= in_valid && in_ready;
    always @(posedge clk) if (fire) acc_cnt <= acc_cnt + 1;

    // core model: low nibble then high nibble per byte, phase cleared by reset
    logic       core_s = 1'b0;
    logic [3:0] core_n = 4'h0;
    logic [3:0] core_lo = 4'h0;
    bit         core_phase = 1'b0;
    logic [7:0] got_mem [64];
    int         got_cnt = 0;
    int         got_base = 0;

    always @(negedge clk) begin
        core_s <= ena && load_en && !reset;
        core_n <= nibble;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_phase <= 1'b0;
        end else if (core_s) begin
            if (!core_phase) begin
                core_lo <= core_n;
            end else if (got_cnt < 64) begin
                got_mem[got_cnt] <= {core_n, core_lo};
                got_cnt <= got_cnt + 1;
            end
            core_phase <= !core_phase;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] src_xor();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < N; i++) x = x ^ src[i];
        return x;
    endfunction

    task automatic begin_session();
        src_base = acc_cnt;
        got_base = got_cnt;
        src_on   = 1'b1;
        stall    = 1'b0;
        ena      = 1'b1;
    endtask

    task automatic check_core(input string tag);
        chk({tag, "_count"}, got_cnt - got_base, N);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_w%0d", tag, i), got_mem[got_base + i], src[i]);
    endtask

    task automatic load_set1();
        logic [7:0] t [N] = '{8'hA0, 8'h41, 8'h7A, 8'h18, 8'hED, 8'hB7,
                              8'h67, 8'h3A, 8'hF9, 8'h62, 8'hF7, 8'h0F};
        for (int i = 0; i < N; i++) src[i] = t[i];
    endtask

    // back-to-back session, cycle 1 = start; optional start pulses while busy and in DONE
    task automatic run_b2b(input bit noise, input string tag);
        logic [7:0] b;
        begin_session();
        start = 1'b1;
        @(negedge clk);
        chk({tag, "_c1_busy"}, busy, 0);
        chk({tag, "_c1_rdy"}, in_ready, 0);
        next_cyc();
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_c2_busy"}, busy, 1);
        chk({tag, "_c2_rdy"}, in_ready, 1);
        chk({tag, "_c2_ld"}, load_en, 0);
        chk({tag, "_c2_idx"}, neuron_idx, 0);
        next_cyc();
        for (int k = 0; k < 2 * N; k++) begin
            start = noise && (k == 7);
            b = src[k / 2];
            @(negedge clk);
            chk($sformatf("%s_ld%0d", tag, k), load_en, 1);
            chk($sformatf("%s_nib%0d", tag, k), nibble, (k % 2) ? b[7:4] : b[3:0]);
            chk($sformatf("%s_idx%0d", tag, k), neuron_idx, k / 2);
            chk($sformatf("%s_rdy%0d", tag, k), in_ready, ((k % 2) == 1) && (k != 2 * N - 1));
            next_cyc();
        end
        start = noise;
        @(negedge clk);
        chk({tag, "_c27_done"}, done, 1);
        chk({tag, "_c27_busy"}, busy, 1);
        chk({tag, "_c27_ld"}, load_en, 0);
        chk({tag, "_c27_nib"}, nibble, 0);
`ifdef BNN_WSTREAM_CHECKSUM_EN
        chk({tag, "_csum"}, checksum, src_xor());
`endif
        next_cyc();
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_c28_done"}, done, 0);
        chk({tag, "_c28_busy"}, busy, 0);
        chk({tag, "_c28_idx"}, neuron_idx, N);
        chk({tag, "_c28_rdy"}, in_ready, 0);
        next_cyc();
        @(negedge clk);
        chk({tag, "_c29_busy"}, busy, 0);
        next_cyc();
        check_core(tag);
    endtask

    // stall after byte 4, ena low for two cycles in the HIGH phase of 0x55
    task automatic run_stall_ena();
        logic [7:0] t [N] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hC4, 8'h55,
                              8'h66, 8'h77, 8'h88, 8'h99, 8'hAB, 8'hCD};
        for (int i = 0; i < N; i++) src[i] = t[i];
        begin_session();
        for (int c = 1; c <= 35; c++) begin
            start = (c == 1);
            stall = (c >= 12) && (c <= 15);
            ena   = !((c == 18) || (c == 19));
            @(negedge clk);
            case (c)
                2: begin
                    chk("st_c2_idx", neuron_idx, 0);
`ifdef BNN_WSTREAM_CHECKSUM_EN
                    chk("st_csum_clr", checksum, 0);
`endif
                end
                12: begin
                    chk("st_c12_ld", load_en, 1);
                    chk("st_c12_nib", nibble, 4'hC);
                end
                13, 14, 15: begin
                    chk($sformatf("st_gap%0d_ld", c), load_en, 0);
                    chk($sformatf("st_gap%0d_rdy", c), in_ready, 1);
                    chk($sformatf("st_gap%0d_idx", c), neuron_idx, 5);
                end
                17: begin
                    chk("st_c17_ld", load_en, 1);
                    chk("st_c17_nib", nibble, 5);
                end
                18, 19: begin
                    chk($sformatf("en%0d_ld", c), load_en, 0);
                    chk($sformatf("en%0d_nib", c), nibble, 5);
                    chk($sformatf("en%0d_idx", c), neuron_idx, 5);
                    chk($sformatf("en%0d_rdy", c), in_ready, 0);
                end
                20: begin
                    chk("en20_ld", load_en, 1);
                    chk("en20_nib", nibble, 5);
                end
                21: begin
                    chk("st_c21_nib", nibble, 6);
                    chk("st_c21_idx", neuron_idx, 6);
                end
                33: begin
                    chk("st_c33_done", done, 1);
`ifdef BNN_WSTREAM_CHECKSUM_EN
                    chk("st_csum", checksum, src_xor());
`endif
                end
                34: begin
                    chk("st_c34_busy", busy, 0);
                    chk("st_c34_idx", neuron_idx, N);
                end
                default: ;
            endcase
            next_cyc();
        end
        check_core("st");
    endtask

    // reset asserted in the LOW phase of byte 6
    task automatic run_reset_mid();
        load_set1();
        begin_session();
        for (int c = 1; c <= 15; c++) begin
            start = (c == 1);
            @(negedge clk);
            if (c < 15) next_cyc();
        end
        chk("rst_pre_ld", load_en, 1);
        chk("rst_pre_nib", nibble, 4'h7);
        chk("rst_pre_idx", neuron_idx, 6);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ld", load_en, 0);
        chk("rst_nib", nibble, 0);
        chk("rst_idx", neuron_idx, 0);
        chk("rst_rdy", in_ready, 0);
        chk("rst_done", done, 0);
`ifdef BNN_WSTREAM_CHECKSUM_EN
        chk("rst_csum", checksum, 0);
`endif
        next_cyc();
        reset = 1'b0;
        src_on = 1'b0;
        next_cyc();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("init_busy", busy, 0);
        chk("init_ld", load_en, 0);
        chk("init_nib", nibble, 0);
        chk("init_idx", neuron_idx, 0);
        chk("init_rdy", in_ready, 0);
        chk("init_done", done, 0);
        next_cyc();
        reset = 1'b0;
        next_cyc();
        load_set1();
        run_b2b(1'b1, "b2b");
        run_stall_ena();
        run_reset_mid();
        load_set1();
        run_b2b(1'b0, "post");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
